mac_seq_ctrl: RTL and testbench
===============================

Name: mac_seq_ctrl

Overview:
- Sequencer directly upstream of the flopoco multiply-accumulate chain (fmac).
- Generates the one-hot fsm_state vector that the chain consumes, with a start/ready handshake per run.
- After the last state it waits out the adder pipeline, captures the final flopoco accumulator result and presents it downstream with a valid/ready handshake and exception flags.
- Sits between the kernel-level scheduler and the fmac instance plus its fmul/fadd cores.

Parameters:
- WE, 8, flopoco exponent width.
- WF, 23, flopoco fraction width; data width DW = WE+WF+3.
- N_STATES, 6, number of schedule states driven to the MAC chain (>= 1).
- DRAIN, 3, cycles to wait after the last state before capturing the result (adder latency, >= 0).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a run; accepted when start && start_ready.
- start_ready  out  1  high only in IDLE.
- fsm_state  out  N_STATES  one-hot schedule; bit i maps to fmac input fsm_state<i>.
- result_in  in  DW  final fadd result from the MAC chain.
- out_data  out  DW  captured result (flopoco format).
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_nan  out  1  exception bits of out_data == 2'b11.
- out_inf  out  1  exception bits of out_data == 2'b10.
- busy  out  1  high in RUN or DRAIN.

Behaviour:
- Reset (rst high at an edge, wins over everything including mid-run):
  - State goes to IDLE.
  - fsm_state=0, out_data=0, out_valid=0, out_nan=0, out_inf=0, busy=0.
  - start_ready=1 in the cycle after reset.
  - Internal counters are cleared.
- States: IDLE, RUN, DRAIN, HOLD.
- IDLE:
  - start_ready=1, fsm_state=0.
  - start high at an edge -> RUN with fsm_state=1 (bit 0) from the next cycle.
- RUN:
  - Exactly one fsm_state bit high; the bit index advances by one each cycle.
  - After bit N_STATES-1 has been high for one cycle: if DRAIN>0 -> DRAIN, else capture and go to HOLD.
  - fsm_state=0 outside RUN.
- DRAIN:
  - Counts DRAIN cycles, fsm_state=0.
  - At the edge ending the last DRAIN cycle: out_data<=result_in, flags computed from result_in[DW-1:DW-2], go to HOLD.
- HOLD:
  - out_valid=1; out_data and flags stable.
  - At an edge with out_ready=1 -> IDLE, out_valid=0. out_data retains its value; flags retain their values.
- Latency: start accepted at edge t.
  - fsm_state bit i high in cycle t+1+i.
  - result captured at edge t+N_STATES+DRAIN.
  - out_valid high from cycle t+N_STATES+DRAIN+1.
- start outside IDLE is ignored (not queued).
- start_ready is low in HOLD: no new run begins until the result is taken.
  - A start asserted in the same cycle as out_ready in HOLD is ignored; it must be re-presented in IDLE.
- Flags: exception code 00 = zero, 01 = normal, 10 = inf, 11 = NaN. out_nan and out_inf are mutually exclusive.
- busy = (state==RUN || state==DRAIN).

Test Plan:
- Reset check: rst high 2 cycles, then low -> start_ready=1, fsm_state=0, out_valid=0, busy=0.
- Nominal run (N_STATES=6, DRAIN=3):
  - Stimulus: start pulse accepted at edge 0; result_in=34'h1_3F80_0000 (1.0).
  - Required: fsm_state = 6'b000001..6'b100000 in cycles 1..6; 0 in cycles 7..9; out_valid=1 from cycle 10 with out_data=34'h1_3F80_0000, out_nan=0, out_inf=0.
- Backpressure: out_ready=0 for 5 cycles after out_valid rises -> out_data and out_valid stable, start pulses ignored, start_ready=0; out_ready=1 -> IDLE next cycle, start_ready=1.
- Exceptions:
  - result_in=34'h3_0000_0000 at capture -> out_nan=1, out_inf=0.
  - result_in=34'h2_0000_0000 -> out_inf=1, out_nan=0.
- Reset mid-operation: rst asserted while fsm_state=6'b000100 -> next cycle all outputs 0, IDLE; a subsequent start yields the full nominal sequence again.
- DRAIN=0 and back-to-back runs:
  - DRAIN=0: capture at the edge ending the cycle where fsm_state=6'b100000.
  - Back-to-back: out_ready held high and start re-asserted in IDLE -> second run's fsm_state bit 0 high exactly one cycle after IDLE acceptance.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// Schedule sequencer for the flopoco MAC chain: walks a one-hot fsm_state through
// N_STATES cycles, waits out the adder pipeline, then holds the captured result on a valid/ready port.
module mac_seq_ctrl #(
    parameter int WE       = 8,
    parameter int WF       = 23,
    parameter int N_STATES = 6,
    parameter int DRAIN    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  start_ready,
    output logic [N_STATES-1:0]   fsm_state,
    input  logic [WE+WF+2:0]      result_in,
    output logic [WE+WF+2:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_nan,
    output logic                  out_inf,
    output logic                  busy
);

    localparam int DW  = WE + WF + 3;
    localparam int IW  = (N_STATES > 1) ? $clog2(N_STATES) : 1;
    localparam int DCW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    // Handshakes: a transfer happens on a rising edge where valid/ready (start/start_ready,
    // out_valid/out_ready) are both high; valid never depends combinationally on ready.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t           state, state_next;
    logic [IW-1:0]    step_idx;
    logic [DCW-1:0]   drain_cnt;
    logic             capture;
    logic             last_step, last_drain;

    assign last_step  = (step_idx == IW'(N_STATES - 1));
    assign last_drain = (drain_cnt == DCW'(DRAIN - 1));

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN: begin
                if (last_step) begin
                    if (DRAIN > 0) begin
                        state_next = S_DRAIN;
                    end else begin
                        capture    = 1'b1;
                        state_next = S_HOLD;
                    end
                end
            end
            S_DRAIN: begin
                if (last_drain) begin
                    capture    = 1'b1;
                    state_next = S_HOLD;
                end
            end
            S_HOLD:  if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Counters only advance while staying in their state, so each entry starts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            step_idx  <= '0;
            drain_cnt <= '0;
            out_data  <= '0;
            out_nan   <= 1'b0;
            out_inf   <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_RUN && state_next == S_RUN) step_idx <= step_idx + 1'b1;
            else                                       step_idx <= '0;
            if (state == S_DRAIN && state_next == S_DRAIN) drain_cnt <= drain_cnt + 1'b1;
            else                                           drain_cnt <= '0;
            if (capture) begin
                out_data <= result_in;
                out_nan  <= (result_in[DW-1:DW-2] == 2'b11);
                out_inf  <= (result_in[DW-1:DW-2] == 2'b10);
            end
        end
    end

    assign start_ready = (state == S_IDLE);
    assign out_valid   = (state == S_HOLD);
    assign busy        = (state == S_RUN) || (state == S_DRAIN);
    assign fsm_state   = (state == S_RUN) ? (N_STATES'(1) << step_idx) : '0;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: one instance with DRAIN=3 and one with DRAIN=0 sharing clock and reset;
// captured results are tracked through an expected queue.
module tb_mac_seq_ctrl;

    localparam int WE = 8;
    localparam int WF = 23;
    localparam int DW = WE + WF + 3;
    localparam int NS = 6;
    localparam int DR = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] result_in = '0;
    logic          start_ready, out_valid, out_nan, out_inf, busy;
    logic [NS-1:0] fsm_state;
    logic [DW-1:0] out_data;

    logic          start0 = 1'b0, out_ready0 = 1'b0;
    logic [DW-1:0] result0 = '0;
    logic          start_ready0, out_valid0, out_nan0, out_inf0, busy0;
    logic [NS-1:0] fsm_state0;
    logic [DW-1:0] out_data0;

    logic [DW-1:0] exp_q[$];
    int            errors = 0;
    int            checks = 0;

    always #5 clk = ~clk;

    mac_seq_ctrl #(.WE(WE), .WF(WF), .N_STATES(NS), .DRAIN(DR)) u_dut (
        .clk(clk), .rst(rst), .start(start), .start_ready(start_ready),
        .fsm_state(fsm_state), .result_in(result_in), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_nan(out_nan),
        .out_inf(out_inf), .busy(busy)
    );

    mac_seq_ctrl #(.WE(WE), .WF(WF), .N_STATES(NS), .DRAIN(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .start_ready(start_ready0),
        .fsm_state(fsm_state0), .result_in(result0), .out_data(out_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_nan(out_nan0),
        .out_inf(out_inf0), .busy(busy0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ctrl vector layout: {fsm_state, busy, start_ready, out_valid}
    task automatic test_reset();
        logic [NS+2:0] ctrl;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        ctrl = {fsm_state, busy, start_ready, out_valid};
        checks++;
        if (ctrl !== {{NS{1'b0}}, 3'b010}) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=%b", ctrl, {{NS{1'b0}}, 3'b010});
        end
        checks++;
        if ({out_data, out_nan, out_inf} !== '0) begin
            errors++;
            $display("FAIL reset_data got=%h nan=%b inf=%b exp=0", out_data, out_nan, out_inf);
        end
        checks++;
        if ({fsm_state0, busy0, start_ready0, out_valid0} !== {{NS{1'b0}}, 3'b010}) begin
            errors++;
            $display("FAIL reset_ctrl_d0 got=%b", {fsm_state0, busy0, start_ready0, out_valid0});
        end
    endtask

    // Full run on the DRAIN=3 instance; result_in carries val only in the last drain cycle.
    task automatic test_run(input logic [DW-1:0] val, input int bp_cycles, input logic start_at_ack);
        logic [DW-1:0] exp;
        logic          exp_nan, exp_inf;
        exp_nan = (val[DW-1:DW-2] == 2'b11);
        exp_inf = (val[DW-1:DW-2] == 2'b10);
        exp_q.push_back(val);
        result_in = ~val;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < NS; i++) begin
            checks++;
            if ({fsm_state, busy, start_ready, out_valid} !== {NS'(1) << i, 3'b100}) begin
                errors++;
                $display("FAIL run_step%0d got=%b exp=%b", i,
                         {fsm_state, busy, start_ready, out_valid}, {NS'(1) << i, 3'b100});
            end
            step();
        end
        for (int d = 0; d < DR; d++) begin
            checks++;
            if ({fsm_state, busy, start_ready, out_valid} !== {{NS{1'b0}}, 3'b100}) begin
                errors++;
                $display("FAIL drain%0d got=%b exp=%b", d,
                         {fsm_state, busy, start_ready, out_valid}, {{NS{1'b0}}, 3'b100});
            end
            if (d == DR - 1) result_in = val;
            step();
        end
        result_in = ~val;
        for (int b = 0; b <= bp_cycles; b++) begin
            checks++;
            if ({busy, start_ready, out_valid, out_nan, out_inf, out_data} !==
                {3'b001, exp_nan, exp_inf, val}) begin
                errors++;
                $display("FAIL hold%0d got v=%b sr=%b busy=%b data=%h nan=%b inf=%b exp data=%h nan=%b inf=%b",
                         b, out_valid, start_ready, busy, out_data, out_nan, out_inf, val, exp_nan, exp_inf);
            end
            if (b < bp_cycles) begin
                start = 1'($urandom_range(0, 1));
                step();
            end
        end
        start = start_at_ack;
        out_ready = 1'b1;
        exp = exp_q.pop_front();
        checks++;
        if (out_data !== exp) begin
            errors++;
            $display("FAIL scoreboard got=%h exp=%h", out_data, exp);
        end
        step();
        out_ready = 1'b0;
        start = 1'b0;
        checks++;
        if ({fsm_state, busy, start_ready, out_valid, out_data, out_nan, out_inf} !==
            {{NS{1'b0}}, 3'b010, val, exp_nan, exp_inf}) begin
            errors++;
            $display("FAIL after_ack got fsm=%b busy=%b sr=%b v=%b data=%h nan=%b inf=%b",
                     fsm_state, busy, start_ready, out_valid, out_data, out_nan, out_inf);
        end
        if (start_at_ack) begin
            step();
            checks++;
            if ({fsm_state, start_ready} !== {{NS{1'b0}}, 1'b1}) begin
                errors++;
                $display("FAIL start_at_ack_ignored got fsm=%b sr=%b exp fsm=0 sr=1", fsm_state, start_ready);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        result_in = 34'h1_4000_0000;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        checks++;
        if (fsm_state !== 6'b000100) begin
            errors++;
            $display("FAIL mid_run_pos got=%b exp=000100", fsm_state);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({fsm_state, busy, start_ready, out_valid, out_nan, out_inf, out_data} !==
            {{NS{1'b0}}, 3'b010, 2'b00, {DW{1'b0}}}) begin
            errors++;
            $display("FAIL mid_run_reset got fsm=%b busy=%b sr=%b v=%b data=%h nan=%b inf=%b",
                     fsm_state, busy, start_ready, out_valid, out_data, out_nan, out_inf);
        end
        step();
        checks++;
        if ({fsm_state, busy} !== {{NS{1'b0}}, 1'b0}) begin
            errors++;
            $display("FAIL mid_run_stays_idle got fsm=%b busy=%b", fsm_state, busy);
        end
    endtask

    // DRAIN=0 instance: capture at the edge ending the fsm_state=100000 cycle, then back-to-back.
    task automatic test_drain_zero_back_to_back(input logic [DW-1:0] val_a, input logic [DW-1:0] val_b);
        logic [DW-1:0] vals[2];
        logic [DW-1:0] exp;
        vals[0] = val_a;
        vals[1] = val_b;
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(vals[r]);
            result0 = ~vals[r];
            start0 = 1'b1;
            step();
            start0 = 1'b0;
            for (int i = 0; i < NS; i++) begin
                checks++;
                if ({fsm_state0, busy0, start_ready0, out_valid0} !== {NS'(1) << i, 3'b100}) begin
                    errors++;
                    $display("FAIL d0_run%0d_step%0d got=%b exp=%b", r, i,
                             {fsm_state0, busy0, start_ready0, out_valid0}, {NS'(1) << i, 3'b100});
                end
                if (i == NS - 1) result0 = vals[r];
                step();
            end
            result0 = ~vals[r];
            checks++;
            if ({fsm_state0, busy0, out_valid0, out_nan0, out_inf0} !==
                {{NS{1'b0}}, 2'b01, vals[r][DW-1:DW-2] == 2'b11, vals[r][DW-1:DW-2] == 2'b10}) begin
                errors++;
                $display("FAIL d0_hold%0d got fsm=%b busy=%b v=%b nan=%b inf=%b", r,
                         fsm_state0, busy0, out_valid0, out_nan0, out_inf0);
            end
            out_ready0 = 1'b1;
            exp = exp_q.pop_front();
            checks++;
            if (out_data0 !== exp) begin
                errors++;
                $display("FAIL d0_scoreboard%0d got=%h exp=%h", r, out_data0, exp);
            end
            step();
            checks++;
            if ({start_ready0, out_valid0} !== 2'b10) begin
                errors++;
                $display("FAIL d0_idle%0d got sr=%b v=%b exp sr=1 v=0", r, start_ready0, out_valid0);
            end
        end
        out_ready0 = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] rnd;
        test_reset();
        test_run(34'h1_3F80_0000, 0, 1'b0);
        test_run(34'h1_4049_0FDB, 5, 1'b1);
        test_run(34'h3_0000_0000, 1, 1'b0);
        test_run(34'h2_0000_0000, 2, 1'b0);
        test_run(34'h0_0000_0000, 0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            rnd = {2'b01, 32'($urandom)};
            test_run(rnd, $urandom_range(0, 4), 1'b0);
        end
        test_reset_mid_run();
        test_run(34'h1_3F80_0000, 0, 1'b0);
        test_drain_zero_back_to_back(34'h1_3F80_0000, 34'h3_0000_0001);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
